// File: rtl/stage3_mem_wb.sv
// Memory/writeback stage of the 3-stage RISC-V pipeline: issues the dcache access
// from the stage2 effective address, registers stage3 state, and drives regfile writeback.
module stage3_mem_wb #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s2_valid,
  input  logic [XLEN-1:0] s2_alu_out,
  input  logic [XLEN-1:0] s2_store_data,
  input  logic [XLEN-1:0] s2_pc_plus4,
  input  logic [2:0]      s2_funct3,
  input  logic            s2_is_load,
  input  logic            s2_is_store,
  input  logic [1:0]      s2_wb_sel,
  input  logic [4:0]      s2_rd,
  input  logic            s2_reg_we,
  input  logic            flush,
  output logic [XLEN-1:0] dcache_addr,
  output logic [XLEN-1:0] dcache_din,
  output logic [3:0]      dcache_we,
  output logic            dcache_re,
  input  logic [XLEN-1:0] dcache_dout,
  input  logic            dcache_stall,
  output logic            stall_out,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Byte enables; misaligned halfword/word stores produce no enables and are dropped.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    store_be = 4'b0000;
    case (f3)
      F3_B:    store_be = 4'b0001 << lo;
      F3_H:    store_be = lo[0] ? 4'b0000 : (lo[1] ? 4'b1100 : 4'b0011);
      F3_W:    store_be = (lo == 2'b00) ? 4'b1111 : 4'b0000;
      default: store_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_align(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] data);
    case (f3)
      F3_B:    store_align = {4{data[7:0]}};
      F3_H:    store_align = {2{data[15:0]}};
      default: store_align = data;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3,
                                                   input logic [1:0] lo,
                                                   input logic [XLEN-1:0] dout);
    logic [XLEN-1:0]  byte_w;
    logic [XLEN-1:0]  half_w;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    byte_w = dout >> {lo, 3'b000};
    half_w = dout >> {lo[1], 4'b0000};
    byte_s = byte_w[7:0];
    half_s = half_w[15:0];
    case (f3)
      F3_B:    load_extract = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_BU:   load_extract = {{(XLEN-8){1'b0}}, byte_w[7:0]};
      F3_H:    load_extract = lo[0] ? '0 : {{(XLEN-16){half_s[15]}}, half_s};
      F3_HU:   load_extract = lo[0] ? '0 : {{(XLEN-16){1'b0}}, half_w[15:0]};
      F3_W:    load_extract = (lo == 2'b00) ? dout : '0;
      default: load_extract = '0;
    endcase
  endfunction

  logic            s3_valid_q, s3_valid_d;
  logic            s3_reg_we_q;
  logic [4:0]      s3_rd_q;
  logic [1:0]      s3_wb_sel_q;
  logic [2:0]      s3_funct3_q;
  logic [1:0]      s3_addr_lo_q;
  logic [XLEN-1:0] s3_alu_q;
  logic [XLEN-1:0] s3_pc4_q;
  logic            req_ok;

  // ---- stage2: dcache request issue (combinational) ----
  // Gating with reset_n keeps the cache quiet while the pipeline is held in reset.
  assign req_ok      = reset_n & s2_valid & ~flush;
  assign dcache_addr = {s2_alu_out[XLEN-1:2], 2'b00};
  assign dcache_re   = req_ok & s2_is_load;
  assign dcache_din  = store_align(s2_funct3, s2_store_data);
  assign dcache_we   = (req_ok & s2_is_store) ? store_be(s2_funct3, s2_alu_out[1:0]) : 4'b0000;
  assign stall_out   = reset_n & dcache_stall;
  assign s3_valid_d  = s2_valid & ~flush;

  // ---- stage2 -> stage3 register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3_valid_q   <= 1'b0;
      s3_reg_we_q  <= 1'b0;
      s3_rd_q      <= '0;
      s3_wb_sel_q  <= '0;
      s3_funct3_q  <= '0;
      s3_addr_lo_q <= '0;
      s3_alu_q     <= '0;
      s3_pc4_q     <= '0;
    end else if (!dcache_stall) begin
      s3_valid_q   <= s3_valid_d;
      s3_reg_we_q  <= s2_reg_we;
      s3_rd_q      <= s2_rd;
      s3_wb_sel_q  <= s2_wb_sel;
      s3_funct3_q  <= s2_funct3;
      s3_addr_lo_q <= s2_alu_out[1:0];
      s3_alu_q     <= s2_alu_out;
      s3_pc4_q     <= s2_pc_plus4;
    end
  end

  // ---- stage3: writeback select (combinational) ----
  assign wb_we = s3_valid_q & s3_reg_we_q & (s3_rd_q != 5'd0) & ~dcache_stall;
  assign wb_rd = s3_rd_q;

  always_comb begin
    wb_data = '0;
    case (s3_wb_sel_q)
      WB_ALU:  wb_data = s3_alu_q;
      WB_MEM:  wb_data = load_extract(s3_funct3_q, s3_addr_lo_q, dcache_dout);
      WB_PC4:  wb_data = s3_pc4_q;
      default: wb_data = '0;
    endcase
  end

endmodule

// File: doc/stage3_mem_wb.md
Name: stage3_mem_wb

Overview:
- Stage following the stage2 execute ALU in the 3-stage RISC-V pipeline.
- Issues the data-cache request from the stage2 ALU result (effective address) and aligns store data.
- Registers the stage2 → stage3 pipeline state, then extracts and sign/zero-extends load data.
- Selects the writeback value and drives the regfile write port and forwarding path. Holds the pipeline while the dcache stalls.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- s2_valid  in  1  stage2 holds a real instruction
- s2_alu_out  in  32  ALU result; the effective address for loads/stores
- s2_store_data  in  32  rs2 value for stores
- s2_pc_plus4  in  32  PC+4 for JAL/JALR writeback
- s2_funct3  in  3  load/store width and sign
- s2_is_load  in  1  load instruction
- s2_is_store  in  1  store instruction
- s2_wb_sel  in  2  writeback source: 0 = ALU, 1 = MEM, 2 = PC+4, 3 = reserved (writes 0)
- s2_rd  in  5  destination register
- s2_reg_we  in  1  instruction writes rd
- flush  in  1  kill the stage2 instruction
- dcache_addr  out  32  word address {s2_alu_out[31:2], 2'b00}
- dcache_din  out  32  aligned store data
- dcache_we  out  4  byte write enables
- dcache_re  out  1  read enable
- dcache_dout  in  32  read data, valid the cycle after re when not stalled
- dcache_stall  in  1  cache busy
- stall_out  out  1  freezes stage1/stage2
- wb_we  out  1  regfile write enable
- wb_rd  out  5  regfile write address
- wb_data  out  32  regfile write data; also the forwarding value

Behaviour:
- Reset (reset_n low, asynchronous):
  - All stage3 registers clear: s3_valid, s3_reg_we, s3_rd, s3_wb_sel, s3_funct3, s3_addr_lo, s3_alu, s3_pc4.
  - Outputs under reset: wb_we = 0, wb_rd = 0, wb_data = 0, stall_out = 0. dcache_re and dcache_we are 0 while reset_n is low.
- Request issue, combinational from stage2 inputs, cycle N:
  - req_ok = s2_valid & !flush.
  - dcache_re = req_ok & s2_is_load.
  - dcache_addr = {s2_alu_out[31:2], 2'b00} always.
- Store alignment:
  - SB: dcache_din = {4{s2_store_data[7:0]}}; dcache_we = 4'b0001 << s2_alu_out[1:0].
  - SH: dcache_din = {2{s2_store_data[15:0]}}; dcache_we = 4'b1100 if addr[1] = 1, else 4'b0011.
  - SW: dcache_din = s2_store_data; dcache_we = 4'b1111.
  - dcache_we = 0 when !req_ok or !s2_is_store.
  - Misaligned SH (addr[0] = 1) or SW (addr[1:0] ≠ 0): dcache_we = 0, store silently dropped.
- Stage register, rising clk edge:
  - If dcache_stall = 1: all stage3 registers hold.
  - Else: capture stage2 fields; s3_valid ← s2_valid & !flush.
  - stall_out = dcache_stall, combinational; upstream holds stage2 inputs stable during a stall.
  - Stall has priority over flush. Upstream keeps flush asserted until the first non-stall edge, and the request stays gated for the whole period.
- Writeback, cycle N+1, combinational from stage3 registers and dcache_dout:
  - wb_we = s3_valid & s3_reg_we & (s3_rd ≠ 0) & !dcache_stall.
  - wb_rd = s3_rd.
  - MEM data, byte = dcache_dout >> (8*addr_lo):
    - LB: sign-extend byte[7:0]; LBU: zero-extend byte[7:0].
    - LH: sign-extend bits [15:0] at addr_lo[1]*16; LHU: zero-extend the same half.
    - LW: dcache_dout.
    - Misaligned LH/LHU/LW: data = 0, write still occurs.
  - wb_sel: ALU → s3_alu; PC+4 → s3_pc4; 3 → 0.
- Latency:
  - Writeback 1 cycle after stage2 when no stall; each stall cycle adds exactly one cycle.
  - No instruction is lost or duplicated across a stall.
- Reset mid-stall: stage3 empties immediately; no writeback occurs after reset release until a new valid instruction arrives.

Test Plan:
- Reset: reset_n = 0 while s2_valid = 1 with a store → dcache_we = 0, wb_we = 0, wb_data = 0. Release, then ADD result 0x0000_0005 to rd = 3 → next cycle wb_we = 1, wb_rd = 3, wb_data = 5.
- Stores: SB to 0x1003 with rs2 = 0x1234_56AB → din = 0xABAB_ABAB, we = 4'b1000. SH to 0x1002 → we = 4'b1100. SW to 0x1001 → we = 0.
- Loads: dout = 0x80FF_7F01 at addr_lo = 1 → LB = 0x0000_007F. At addr_lo = 3: LB = 0xFFFF_FF80, LBU = 0x0000_0080. At addr_lo = 2: LH = 0xFFFF_80FF, LHU = 0x0000_80FF.
- Stall: LW issued, dcache_stall high for 3 cycles → stall_out high 3 cycles, wb_we = 0 throughout, stage3 state unchanged. Writeback occurs exactly once on release with the correct dout.
- Flush and x0: flush with a store in stage2 → we = 0, next cycle wb_we = 0. flush held across a 2-cycle stall → still bubbled. JAL with rd = 0 → wb_we = 0. JAL with rd = 1, pc+4 = 0x104 → wb_data = 0x104.
- Back-to-back: LW, ADD, SB with no stalls → three consecutive writebacks or stores in order, one per cycle.
